// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment display path.
//   db_state_t : debounce FSM states
//   BCD_MAX    : terminal value of one decimal digit
//   BCD_DIGITS : number of digits in the packed BCD count
package display_pkg;

  typedef enum logic [1:0] {
    IDLE_LO,
    WAIT_HI,
    IDLE_HI,
    WAIT_LO
  } db_state_t;

  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam int         BCD_DIGITS = 4;

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: counts up (0..9) or down (9..0) when enabled.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_clr          : synchronous clear to 0, overrides i_en
//   i_en           : step this digit on the next edge
//   i_dir          : 0 = up, 1 = down
//   o_q            : current digit value, always 0..9
//   o_co           : combinational carry/borrow out (enabled and at terminal value)
module bcd_digit
  import display_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_dir,
  output logic [3:0] o_q,
  output logic       o_co
);

  logic [3:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_reset)     r_q <= 4'd0;
    else if (i_clr)  r_q <= 4'd0;
    else if (i_en) begin
      if (i_dir) r_q <= (r_q == 4'd0)    ? BCD_MAX : r_q - 4'd1;
      else       r_q <= (r_q == BCD_MAX) ? 4'd0    : r_q + 4'd1;
    end
  end

  assign o_q  = r_q;
  assign o_co = i_en & (i_dir ? (r_q == 4'd0) : (r_q == BCD_MAX));

endmodule

// File: rtl/debounce_bcd_counter.sv
// Push-button front end for the 4-digit display: synchronises and debounces
// a raw button, emits one press pulse per accepted press, and keeps a packed
// 4-digit BCD up/down count.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_btn_raw      : asynchronous bouncing button level (1 = pressed)
//   i_dir          : count direction on the press cycle (0 = up, 1 = down)
//   i_clr          : synchronous clear of the count (beats a press)
//   o_count        : packed BCD count, digit 3 in [15:12]
//   o_btn_stable   : debounced button level
//   o_press        : one-cycle pulse per accepted press
//   o_wrap         : one-cycle pulse on 9999->0000 or 0000->9999
module debounce_bcd_counter
  import display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_btn_raw,
  input  logic        i_dir,
  input  logic        i_clr,
  output logic [15:0] o_count,
  output logic        o_btn_stable,
  output logic        o_press,
  output logic        o_wrap
);

  localparam int              TW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [TW-1:0]   TMAX = TW'(DEBOUNCE_CYCLES - 1);

  logic                          r_s1, r_btn_s;
  db_state_t                     r_state, w_state_nxt;
  logic [TW-1:0]                 r_timer, w_timer_nxt;
  logic                          w_press_nxt;
  logic                          r_stable, r_press, r_wrap;
  logic [BCD_DIGITS-1:0]         w_en, w_co;
  logic [BCD_DIGITS-1:0][3:0]    w_q;

  // Qualification: a level change is accepted only after the timer walks
  // 0..TMAX with the synchronised level held; any bounce drops back to idle.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_press_nxt = 1'b0;
    case (r_state)
      IDLE_LO: if (r_btn_s) begin
        w_state_nxt = WAIT_HI;
        w_timer_nxt = '0;
      end
      WAIT_HI: begin
        if (!r_btn_s)              w_state_nxt = IDLE_LO;
        else if (r_timer == TMAX) begin
          w_state_nxt = IDLE_HI;
          w_press_nxt = 1'b1;
        end else                   w_timer_nxt = r_timer + 1'b1;
      end
      IDLE_HI: if (!r_btn_s) begin
        w_state_nxt = WAIT_LO;
        w_timer_nxt = '0;
      end
      WAIT_LO: begin
        if (r_btn_s)               w_state_nxt = IDLE_HI;
        else if (r_timer == TMAX)  w_state_nxt = IDLE_LO;
        else                       w_timer_nxt = r_timer + 1'b1;
      end
      default: w_state_nxt = IDLE_LO;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1     <= 1'b0;
      r_btn_s  <= 1'b0;
      r_state  <= IDLE_LO;
      r_timer  <= '0;
      r_stable <= 1'b0;
      r_press  <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_s1     <= i_btn_raw;
      r_btn_s  <= r_s1;
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      // Debounced level is high while the FSM believes the button is down.
      r_stable <= (w_state_nxt == IDLE_HI) || (w_state_nxt == WAIT_LO);
      r_press  <= w_press_nxt;
      // Carry/borrow out of the top digit; a clear swallows the press.
      r_wrap   <= w_co[BCD_DIGITS-1] & ~i_clr;
    end
  end

  // Ripple enable chain: each digit steps only when all lower digits roll.
  genvar n;
  generate
    for (n = 0; n < BCD_DIGITS; n++) begin : g_digit
      if (n == 0) begin : g_en0
        assign w_en[n] = r_press;
      end else begin : g_enn
        assign w_en[n] = r_press & w_co[n-1];
      end
      bcd_digit u_digit (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (i_clr),
        .i_en    (w_en[n]),
        .i_dir   (i_dir),
        .o_q     (w_q[n]),
        .o_co    (w_co[n])
      );
    end
  endgenerate

  assign o_count      = w_q;
  assign o_btn_stable = r_stable;
  assign o_press      = r_press;
  assign o_wrap       = r_wrap;

endmodule
